// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

    localparam int PIPE_STAGES_DEF = 3;
    localparam int ADDR_W_DEF      = 5;
    localparam int FWD_W_DEF       = $clog2(PIPE_STAGES_DEF + 1);
    localparam int CNT_W_DEF       = 32;

    // Forward-select code meaning "read the register file"; k+1 selects entry k.
    localparam int FWD_SRC_RF      = 0;

    // Per-cycle decision, in priority order FREEZE > FLUSH > STALL > ISSUE.
    typedef enum logic [1:0] {
        ACT_ISSUE  = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } action_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the pipeline front end and the hazard controller.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FWD_W  = FWD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    // No valid/ready pair: decode presents an instruction every cycle and the
    // controller answers in the same cycle; stall_front=1 means the source must
    // re-present the same instruction next cycle, freeze/redirect are levels.
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_rs_use;
    logic              id_rt_use;
    logic [ADDR_W-1:0] id_dst;
    logic              id_we;
    logic              id_is_load;
    logic              redirect;
    logic              freeze;

    logic [FWD_W-1:0]  fwd_rs;
    logic [FWD_W-1:0]  fwd_rt;
    logic              stall_front;
    logic              bubble;
    logic              flush_ifid;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    action_e           dbg_action;

    modport master (
        output id_rs, id_rt, id_rs_use, id_rt_use, id_dst, id_we, id_is_load,
               redirect, freeze,
        input  fwd_rs, fwd_rt, stall_front, bubble, flush_ifid,
               stall_cnt, flush_cnt, dbg_action
    );

    modport slave (
        input  id_rs, id_rt, id_rs_use, id_rt_use, id_dst, id_we, id_is_load,
               redirect, freeze,
        output fwd_rs, fwd_rt, stall_front, bubble, flush_ifid,
               stall_cnt, flush_cnt, dbg_action
    );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: increments on inc unless hold is set, sticks at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i && inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: destination scoreboard for the post-decode
// stages, per-operand forward select, load-use stall, redirect flush, freeze.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STAGES     = PIPE_STAGES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int FWD_W      = $clog2(STAGES + 1),
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);

    // Scoreboard: entry 0 = EXE, entry STAGES-1 = last stage before RF write.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] load_q,  load_d;
    logic [ADDR_W-1:0] dst_q [STAGES];
    logic [ADDR_W-1:0] dst_d [STAGES];

    logic [STAGES-1:0] match_rs;
    logic [STAGES-1:0] match_rt;
    logic [STAGES-1:0] ready;

    logic [FWD_W-1:0]  fwd_rs_raw;
    logic [FWD_W-1:0]  fwd_rt_raw;
    logic              haz_rs;
    logic              haz_rt;
    logic              hazard;
    action_e           act;

    for (genvar k = 0; k < STAGES; k++) begin : g_entry
        localparam bit ALU_OK  = (k >= ALU_READY);
        localparam bit LOAD_OK = (k >= LOAD_READY);

        assign match_rs[k] = valid_q[k] && (dst_q[k] == bus.id_rs) &&
                             (bus.id_rs != '0) && bus.id_rs_use;
        assign match_rt[k] = valid_q[k] && (dst_q[k] == bus.id_rt) &&
                             (bus.id_rt != '0) && bus.id_rt_use;
        assign ready[k]    = load_q[k] ? LOAD_OK : ALU_OK;
    end

    // Walk from oldest to youngest so the lowest matching index wins.
    always_comb begin
        fwd_rs_raw = FWD_W'(FWD_SRC_RF);
        fwd_rt_raw = FWD_W'(FWD_SRC_RF);
        haz_rs     = 1'b0;
        haz_rt     = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (match_rs[k]) begin
                fwd_rs_raw = ready[k] ? FWD_W'(k + 1) : FWD_W'(FWD_SRC_RF);
                haz_rs     = !ready[k];
            end
            if (match_rt[k]) begin
                fwd_rt_raw = ready[k] ? FWD_W'(k + 1) : FWD_W'(FWD_SRC_RF);
                haz_rt     = !ready[k];
            end
        end
    end

    assign hazard = haz_rs || haz_rt;

    always_comb begin
        if (bus.freeze) begin
            act = ACT_FREEZE;
        end else if (bus.redirect) begin
            act = ACT_FLUSH;
        end else if (hazard) begin
            act = ACT_STALL;
        end else begin
            act = ACT_ISSUE;
        end
    end

    // A redirecting instruction still proceeds, so FLUSH shifts it in like ISSUE.
    always_comb begin
        valid_d = valid_q;
        load_d  = load_q;
        for (int k = 0; k < STAGES; k++) begin
            dst_d[k] = dst_q[k];
        end
        if (act != ACT_FREEZE) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                valid_d[k] = valid_q[k-1];
                load_d[k]  = load_q[k-1];
                dst_d[k]   = dst_q[k-1];
            end
            if (act == ACT_STALL) begin
                valid_d[0] = 1'b0;
                load_d[0]  = 1'b0;
                dst_d[0]   = '0;
            end else begin
                valid_d[0] = bus.id_we && (bus.id_dst != '0);
                load_d[0]  = bus.id_is_load;
                dst_d[0]   = bus.id_dst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            load_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dst_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            for (int k = 0; k < STAGES; k++) begin
                dst_q[k] <= dst_d[k];
            end
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .inc_i  (act == ACT_STALL),
        .hold_i (act == ACT_FREEZE),
        .cnt_o  (bus.stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .inc_i  (act == ACT_FLUSH),
        .hold_i (act == ACT_FREEZE),
        .cnt_o  (bus.flush_cnt)
    );

    // Combinational outputs are forced low while reset is asserted.
    assign bus.fwd_rs      = rst ? fwd_rs_raw : '0;
    assign bus.fwd_rt      = rst ? fwd_rt_raw : '0;
    assign bus.stall_front = rst && ((act == ACT_FREEZE) || (act == ACT_STALL));
    assign bus.bubble      = rst && (act == ACT_STALL);
    assign bus.flush_ifid  = rst && (act == ACT_FLUSH);
    assign bus.dbg_action  = act;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed pipeline scenarios plus a
// random phase, all checked against a reference model through an expected queue.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int STAGES     = 3;
  localparam int ADDR_W     = 5;
  localparam int ALU_READY  = 1;
  localparam int LOAD_READY = 2;
  localparam int FWD_W      = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             skip_fwd;
    logic [FWD_W-1:0] fwd_rs;
    logic [FWD_W-1:0] fwd_rt;
    logic             stall_front;
    logic             bubble;
    logic             flush_ifid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
  } exp_t;

  localparam int W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.ADDR_W(ADDR_W), .FWD_W(FWD_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .STAGES(STAGES), .ADDR_W(ADDR_W), .ALU_READY(ALU_READY),
    .LOAD_READY(LOAD_READY), .FWD_W(FWD_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  bit                m_v [STAGES];
  bit                m_l [STAGES];
  logic [ADDR_W-1:0] m_d [STAGES];
  int                m_stall, m_flush;
  bit                e_haz;
  int                e_rs, e_rt;

  // last observed values, for scenario-level checks
  int last_fwd_rs, last_fwd_rt, last_bubble, last_flush, last_stall_front;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = 0; m_l[k] = 0; m_d[k] = '0;
    end
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_eval();
    bit found_rs, found_rt;
    int need;
    e_haz = 0; e_rs = 0; e_rt = 0;
    found_rs = 0; found_rt = 0;
    for (int k = 0; k < STAGES; k++) begin
      need = m_l[k] ? LOAD_READY : ALU_READY;
      if (!found_rs && m_v[k] && bus.id_rs_use && bus.id_rs != 0 && m_d[k] == bus.id_rs) begin
        found_rs = 1;
        if (k >= need) e_rs = k + 1; else e_haz = 1;
      end
      if (!found_rt && m_v[k] && bus.id_rt_use && bus.id_rt != 0 && m_d[k] == bus.id_rt) begin
        found_rt = 1;
        if (k >= need) e_rt = k + 1; else e_haz = 1;
      end
    end
  endtask

  task automatic model_update();
    bit ins;
    if (!rst || bus.freeze) return;
    if (bus.redirect) begin
      if (m_flush < CNT_MAX) m_flush++;
      ins = 1;
    end else if (e_haz) begin
      if (m_stall < CNT_MAX) m_stall++;
      ins = 0;
    end else begin
      ins = 1;
    end
    for (int k = STAGES - 1; k >= 1; k--) begin
      m_v[k] = m_v[k-1]; m_l[k] = m_l[k-1]; m_d[k] = m_d[k-1];
    end
    m_v[0] = ins && bus.id_we && (bus.id_dst != 0);
    m_l[0] = bus.id_is_load;
    m_d[0] = bus.id_dst;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int rs, input int rt, input bit rsu, input bit rtu,
                       input int dst, input bit we, input bit ld,
                       input bit redir, input bit frz);
    bus.id_rs      = ADDR_W'(rs);
    bus.id_rt      = ADDR_W'(rt);
    bus.id_rs_use  = rsu;
    bus.id_rt_use  = rtu;
    bus.id_dst     = ADDR_W'(dst);
    bus.id_we      = we;
    bus.id_is_load = ld;
    bus.redirect   = redir;
    bus.freeze     = frz;
  endtask

  // One clock: called at posedge+1 with inputs already driven.
  task automatic cycle();
    exp_t e;
    exp_t x;
    model_eval();
    e = '0;
    if (rst) begin
      e.skip_fwd    = e_haz && !bus.freeze && !bus.redirect;
      e.fwd_rs      = FWD_W'(e_rs);
      e.fwd_rt      = FWD_W'(e_rt);
      e.stall_front = bus.freeze || (!bus.redirect && e_haz);
      e.bubble      = !bus.freeze && !bus.redirect && e_haz;
      e.flush_ifid  = !bus.freeze && bus.redirect;
    end
    e.stall_cnt = CNT_W'(m_stall);
    e.flush_cnt = CNT_W'(m_flush);
    exp_q.push_back(W'(e));

    @(negedge clk);
    x = exp_t'(exp_q.pop_front());
    if (!x.skip_fwd) begin
      check_eq("fwd_rs", 32'(bus.fwd_rs), 32'(x.fwd_rs));
      check_eq("fwd_rt", 32'(bus.fwd_rt), 32'(x.fwd_rt));
    end
    check_eq("stall_front", 32'(bus.stall_front), 32'(x.stall_front));
    check_eq("bubble",      32'(bus.bubble),      32'(x.bubble));
    check_eq("flush_ifid",  32'(bus.flush_ifid),  32'(x.flush_ifid));
    check_eq("stall_cnt",   32'(bus.stall_cnt),   32'(x.stall_cnt));
    check_eq("flush_cnt",   32'(bus.flush_cnt),   32'(x.flush_cnt));
    last_fwd_rs      = int'(bus.fwd_rs);
    last_fwd_rt      = int'(bus.fwd_rt);
    last_bubble      = int'(bus.bubble);
    last_flush       = int'(bus.flush_ifid);
    last_stall_front = int'(bus.stall_front);

    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cycle();
    rst = 1'b1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit keep;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // 1: ALU producer then dependent consumer -> one stall, then forward from entry 1
    do_reset();
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0); cycle();
    drive(3, 0, 1, 0, 4, 1, 0, 0, 0); cycle();
    check_eq("p1_first_bubble", 32'(last_bubble), 32'd1);
    cycle();
    check_eq("p1_fwd_rs", 32'(last_fwd_rs), 32'd2);
    check_eq("p1_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // 2: load then dependent consumer -> two stalls, then forward from entry 2
    do_reset();
    drive(0, 0, 0, 0, 5, 1, 1, 0, 0); cycle();
    drive(5, 0, 1, 0, 6, 1, 0, 0, 0); cycle(); cycle();
    check_eq("p2_second_bubble", 32'(last_bubble), 32'd1);
    cycle();
    check_eq("p2_fwd_rs", 32'(last_fwd_rs), 32'd3);
    check_eq("p2_stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // 3: writes to r0 are never tracked
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0); cycle();
    drive(0, 0, 1, 1, 2, 1, 0, 0, 0); cycle();
    check_eq("p3_fwd_rs", 32'(last_fwd_rs), 32'd0);
    check_eq("p3_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // 4: two writers to r7 in flight -> youngest (entry 1) wins
    do_reset();
    drive(0, 0, 0, 0, 7, 1, 0, 0, 0); cycle(); cycle();
    nop();
    drive(0, 7, 0, 1, 8, 1, 0, 0, 0); cycle();
    check_eq("p4_fwd_rt", 32'(last_fwd_rt), 32'd2);

    // 5: redirect wins over a pending load-use hazard
    do_reset();
    drive(0, 0, 0, 0, 5, 1, 1, 0, 0); cycle();
    drive(5, 0, 1, 0, 6, 1, 0, 1, 0); cycle();
    check_eq("p5_flush", 32'(last_flush), 32'd1);
    check_eq("p5_bubble", 32'(last_bubble), 32'd0);
    check_eq("p5_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check_eq("p5_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // 6: freeze holds everything, then a mid-stream reset forgets writers
    do_reset();
    drive(0, 0, 0, 0, 5, 1, 1, 0, 0); cycle();
    drive(5, 0, 1, 0, 6, 1, 0, 0, 1); cycle(); cycle(); cycle();
    check_eq("p6_freeze_stall_front", 32'(last_stall_front), 32'd1);
    check_eq("p6_freeze_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    drive(5, 0, 1, 0, 6, 1, 0, 0, 0); cycle();
    check_eq("p6_unfrozen_bubble", 32'(last_bubble), 32'd1);
    drive(0, 0, 0, 0, 9, 1, 1, 0, 0); cycle();
    do_reset();
    drive(9, 0, 1, 0, 10, 1, 0, 0, 0); cycle();
    check_eq("p6_after_rst_bubble", 32'(last_bubble), 32'd0);
    check_eq("p6_after_rst_fwd", 32'(last_fwd_rs), 32'd0);
    check_eq("p6_after_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // random phase: small register range for frequent hits; long enough to saturate
    do_reset();
    keep = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        keep = 0;
      end else begin
        if (!keep) begin
          drive($urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 0, 0);
        end
        bus.redirect = ($urandom_range(0, 7) == 0);
        bus.freeze   = ($urandom_range(0, 9) == 0);
        cycle();
        keep = (last_stall_front != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog in case the stimulus process ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
